// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order retirement of out-of-order writebacks.
// Optional ROB_BYPASS_EN lets a writeback to the waiting head commit at once.
module rob_commit_unit #(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 8,
  parameter int REG_W  = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_rob_ind,
  input  logic [DATA_W-1:0] wb_data,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [IDX_W-1:0]  commit_rob_ind,
  output logic [IDX_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [REG_W-1:0]  rd_q [DEPTH];
  logic [REG_W-1:0]  rd_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              cv_q, cv_d;
  logic [REG_W-1:0]  crd_q, crd_d;
  logic [DATA_W-1:0] cdata_q, cdata_d;
  logic [IDX_W-1:0]  cind_q, cind_d;

  logic do_alloc;
  logic wb_hit;
  logic head_rdy;
  logic byp;
  logic do_commit;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign alloc_ready = !full;
  assign alloc_idx   = tail_q;
  assign count       = count_q;

  assign commit_valid   = cv_q;
  assign commit_rd      = crd_q;
  assign commit_data    = cdata_q;
  assign commit_rob_ind = cind_q;

  assign do_alloc = alloc_valid && alloc_ready;
  assign wb_hit   = wb_valid && busy_q[wb_rob_ind];
  assign head_rdy = busy_q[head_q] && ready_q[head_q];

`ifdef ROB_BYPASS_EN
  assign byp = wb_hit && (wb_rob_ind == head_q) && !ready_q[head_q];
`else
  assign byp = 1'b0;
`endif

  assign do_commit = head_rdy || byp;

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cv_d    = 1'b0;
    crd_d   = crd_q;
    cdata_d = cdata_q;
    cind_d  = cind_q;

    if (wb_hit) begin
      ready_d[wb_rob_ind] = 1'b1;
      data_d[wb_rob_ind]  = wb_data;
    end

    if (do_commit) begin
      cv_d            = 1'b1;
      crd_d           = rd_q[head_q];
      cdata_d         = byp ? wb_data : data_q[head_q];
      cind_d          = head_q;
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + IDX_W'(1);
    end

    // tail is never busy, so this cannot collide with the writeback above
    if (do_alloc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      rd_d[tail_q]    = alloc_rd;
      tail_d          = tail_q + IDX_W'(1);
    end

    count_d = count_q + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_commit);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      ready_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      crd_q   <= '0;
      cdata_q <= '0;
      cind_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      crd_q   <= crd_d;
      cdata_q <= cdata_d;
      cind_q  <= cind_d;
    end
  end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer on the result side of the execution units.
- Issue allocates an entry per instruction and receives its index (rob_ind).
- Execution units write results back by rob_ind, in any order.
- The block retires completed entries strictly in program order and drives the register-bank write port, one commit per cycle.

Parameters:
IDX_W, 3, entry index width; depth = 2**IDX_W (8 entries)
DATA_W, 8, result data width
REG_W, 4, destination register index width (16 registers)

Ports:
clk1  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alloc_valid  in  1  issue requests a new entry this cycle
alloc_rd  in  REG_W  destination register of the issuing instruction
alloc_ready  out  1  entry available; equals !full (combinational from state)
alloc_idx  out  IDX_W  index granted to the allocation (current tail, combinational)
wb_valid  in  1  execution unit result valid
wb_rob_ind  in  IDX_W  entry being written back
wb_data  in  DATA_W  result value
commit_valid  out  1  registered; one-cycle pulse per retired entry
commit_rd  out  REG_W  destination register of the retired entry
commit_data  out  DATA_W  value to write into the register bank
commit_rob_ind  out  IDX_W  index retired; the register bank clears its tag only if the tag matches
count  out  IDX_W+1  number of occupied entries
full  out  1  count == 2**IDX_W
empty  out  1  count == 0

Behaviour:
- Storage per entry: busy, ready, rd, data.
- Pointers: head (oldest entry), tail (next free entry), both IDX_W bits and wrapping modulo depth.
- count is a separate IDX_W+1 register, so full and empty are unambiguous when head == tail.
- Reset (async, rst_n low): all busy/ready cleared, head = tail = 0, count = 0, commit_valid = 0, commit_rd/data/rob_ind = 0. Outputs are at these values while rst_n is low.
- Reset mid-operation discards all in-flight entries; no commit is emitted for them.
- Allocation: alloc_valid && alloc_ready at an edge writes entry[tail] = {busy=1, ready=0, rd=alloc_rd} and increments tail. alloc_valid while full is ignored; the issuer must stall.
- Writeback: wb_valid at an edge with entry[wb_rob_ind].busy sets ready = 1 and data = wb_data. Writeback to a non-busy entry is ignored. A second writeback to an already-ready entry overwrites data.
- Commit: at each edge, if entry[head].busy && entry[head].ready (state before the edge):
  - commit_valid <= 1;
  - commit_rd/data/rob_ind <= the head entry's fields;
  - the entry's busy and ready are cleared;
  - head increments.
  Otherwise commit_valid <= 0; commit_rd/data/rob_ind hold their last values.
- Latency: a writeback sampled at edge N gives commit_valid high after edge N+1 at the earliest.
- Simultaneous events:
  - Alloc and commit in the same cycle: count unchanged; both pointers advance.
  - Alloc when full is refused even if a commit occurs that cycle (alloc_ready reflects pre-edge state).
  - Writeback to the head entry in the same cycle it would otherwise be checked for commit: no commit that edge (ready is not yet set), except with the optional feature.
  - Writeback and alloc targeting the same index: impossible, since the tail entry is never busy.
- Wrap-around: after index 2**IDX_W-1, pointers return to 0. Ordering is preserved across the wrap.
- Out-of-order writebacks never cause out-of-order commits. Younger ready entries wait behind a non-ready head.

Optional Feature:
ROB_BYPASS_EN
- Defined: a writeback with wb_rob_ind == head, to a busy and not-yet-ready head, commits at the same edge.
  - commit_data = wb_data.
  - Write-back-to-commit latency drops to 1 edge.
  - The entry is freed without its stored data being used.
- Undefined: behaviour exactly as above (2-edge minimum).

Test Plan:
- Reset: rst_n low mid-stream with 3 entries busy -> count=0, empty=1, commit_valid=0 immediately; no commits after release.
- In-order flow:
  - Sequence: alloc rd=5 (idx 0), wb idx0 data=0x2A.
  - Commit side: commit_valid pulse one edge after wb, with rd=5, data=0x2A, rob_ind=0.
  - Occupancy: count returns to 0.
- Out-of-order writeback:
  - Sequence: alloc rd=1,2,3 (idx 0,1,2); wb idx2=0x33, idx1=0x22, then idx0=0x11.
  - Commit side: no commit until idx0 is written; then three consecutive commit pulses rd=1/0x11, rd=2/0x22, rd=3/0x33.
- Full/wrap:
  - Full: alloc 8 entries -> full=1, alloc_ready=0; a 9th alloc is ignored and tail is unchanged.
  - Drain: commit 2 entries, then alloc 2 more -> granted alloc_idx=0, then 1.
  - Order: commits continue in order across the wrap.
- Spurious writeback: wb_valid to idx 4 while empty -> no state change, no commit, count stays 0.
- Bypass (ROB_BYPASS_EN defined): alloc rd=7 idx0, wb idx0=0x5A -> commit_valid at the same edge as wb, data=0x5A. Without the macro, the same stimulus commits one edge later.
